// File: rtl/mdu_ctrl_if.sv
// Handshake and strobe bundle between the E-stage issue logic and the
// multiply/divide controller.
interface mdu_ctrl_if;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic       flush;
  logic       cmd_ready;
  logic       start;
  logic [2:0] mdu_op;
  logic       hi_write;
  logic       lo_write;
  logic       commit;
  logic       busy;
  logic       stall;

  // Pipeline side: presents commands, observes strobes and stall.
  modport master (
    output cmd_valid, cmd_op, flush,
    input  cmd_ready, start, mdu_op, hi_write, lo_write, commit, busy, stall
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_op, flush,
    output cmd_ready, start, mdu_op, hi_write, lo_write, commit, busy, stall
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller: launches the iterative datapath,
// counts its latency, stalls the pipeline while it runs and strobes the
// HI/LO commit. MTHI/MTLO write directly; MFHI/MFLO need no strobes.
module mdu_ctrl #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input logic     clk,
  input logic     reset,
  mdu_ctrl_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  state_t     state;
  logic [3:0] cnt;
  logic       busy_q;
  logic       idle;
  logic       go;

  assign idle = (state == IDLE);

  // A presented command is consumed in IDLE; flush discards it (still
  // consumed, so no stall) by suppressing every strobe.
  assign go = reset & idle & bus.cmd_valid & ~bus.flush;

  assign bus.cmd_ready = reset & idle;
  assign bus.start     = go & ~bus.cmd_op[2];
  assign bus.mdu_op    = bus.start ? {1'b0, bus.cmd_op[1:0]} : 3'b000;
  assign bus.hi_write  = go & (bus.cmd_op == 3'b100);
  assign bus.lo_write  = go & (bus.cmd_op == 3'b101);
  // Commit only happens in RUN and the write strobes only in IDLE, so the
  // two groups are mutually exclusive by construction.
  assign bus.commit    = reset & ~idle & (cnt == 4'd1) & ~bus.flush;
  // Held low while reset is asserted, even on the first reset cycle.
  assign bus.busy      = busy_q & reset;
  assign bus.stall     = reset & bus.cmd_valid & ~idle;

  // State, latency counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            cnt    <= bus.cmd_op[1] ? DIV_CNT : MUL_CNT;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          // Flush (even in the commit cycle) abandons the result.
          if (bus.flush || cnt == 4'd1) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= 4'd0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with default latencies (MUL 5, DIV 10).
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge. Output vector order:
// {cmd_ready, start, mdu_op[2:0], hi_write, lo_write, commit, busy, stall}
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total  = 0;
  int passed = 0;
  int commit_cnt = 0;

  logic [9:0] obs;
  assign obs = {bus.cmd_ready, bus.start, bus.mdu_op, bus.hi_write,
                bus.lo_write, bus.commit, bus.busy, bus.stall};

  always @(posedge clk) if (bus.commit === 1'b1) commit_cnt++;

  function automatic logic [9:0] ev(input logic rdy, input logic st,
                                    input logic [2:0] op, input logic hw,
                                    input logic lw, input logic cm,
                                    input logic bz, input logic sl);
    return {rdy, st, op, hw, lw, cm, bz, sl};
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic f);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.flush     = f;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    reset = 1'b0;
    drive(1'b1, 3'b001, 1'b0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    e = '0;
    total++;
    if (obs !== e) $display("FAIL reset_outputs obs=%b exp=%b", obs, e);
    else passed++;
    next_cycle();
    reset = 1'b1;
    drive(1'b0, 3'b000, 1'b0);
    @(negedge clk);
    e = ev(1, 0, 3'b000, 0, 0, 0, 0, 0);
    total++;
    if (obs !== e) $display("FAIL reset_idle obs=%b exp=%b", obs, e);
    else passed++;
    next_cycle();
  endtask

  task automatic test_mult();
    logic [9:0] e;
    int c0 = commit_cnt;
    for (int c = 0; c <= 6; c++) begin
      drive(c == 0, 3'b001, 1'b0);
      @(negedge clk);
      e = ev(c == 0 || c == 6, c == 0, (c == 0) ? 3'b001 : 3'b000, 0, 0,
             c == 5, c >= 1 && c <= 5, 0);
      total++;
      if (obs !== e) $display("FAIL mult c%0d obs=%b exp=%b", c, obs, e);
      else passed++;
      next_cycle();
    end
    total++;
    if (commit_cnt - c0 !== 1) $display("FAIL mult_commits got=%0d exp=1", commit_cnt - c0);
    else passed++;
  endtask

  task automatic test_divu_mflo();
    logic [9:0] e;
    for (int c = 0; c <= 11; c++) begin
      if (c == 0) drive(1'b1, 3'b010, 1'b0);
      else        drive(1'b1, 3'b111, 1'b0);
      @(negedge clk);
      e = ev(c == 0 || c == 11, c == 0, (c == 0) ? 3'b010 : 3'b000, 0, 0,
             c == 10, c >= 1 && c <= 10, c >= 1 && c <= 10);
      total++;
      if (obs !== e) $display("FAIL divu_mflo c%0d obs=%b exp=%b", c, obs, e);
      else passed++;
      next_cycle();
    end
    drive(1'b0, 3'b000, 1'b0);
  endtask

  task automatic test_mt_and_idle_flush();
    logic [9:0] e;
    drive(1'b1, 3'b100, 1'b0);
    @(negedge clk);
    e = ev(1, 0, 3'b000, 1, 0, 0, 0, 0);
    total++;
    if (obs !== e) $display("FAIL mthi obs=%b exp=%b", obs, e);
    else passed++;
    next_cycle();
    drive(1'b1, 3'b101, 1'b0);
    @(negedge clk);
    e = ev(1, 0, 3'b000, 0, 1, 0, 0, 0);
    total++;
    if (obs !== e) $display("FAIL mtlo obs=%b exp=%b", obs, e);
    else passed++;
    next_cycle();
    drive(1'b1, 3'b001, 1'b1);
    @(negedge clk);
    e = ev(1, 0, 3'b000, 0, 0, 0, 0, 0);
    total++;
    if (obs !== e) $display("FAIL idle_flush obs=%b exp=%b", obs, e);
    else passed++;
    next_cycle();
    drive(1'b0, 3'b000, 1'b0);
    @(negedge clk);
    e = ev(1, 0, 3'b000, 0, 0, 0, 0, 0);
    total++;
    if (obs !== e) $display("FAIL after_mt_flush obs=%b exp=%b", obs, e);
    else passed++;
    next_cycle();
  endtask

  task automatic test_flush_run();
    logic [9:0] e;
    int c0 = commit_cnt;
    for (int c = 0; c <= 11; c++) begin
      drive(c == 0, 3'b011, c == 10);
      @(negedge clk);
      e = ev(c == 0 || c == 11, c == 0, (c == 0) ? 3'b011 : 3'b000, 0, 0,
             0, c >= 1 && c <= 10, 0);
      total++;
      if (obs !== e) $display("FAIL div_flush c%0d obs=%b exp=%b", c, obs, e);
      else passed++;
      next_cycle();
    end
    total++;
    if (commit_cnt != c0) $display("FAIL div_flush_commits got=%0d exp=0", commit_cnt - c0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [9:0] e;
    logic [3:0] m;
    int c0 = commit_cnt;
    for (int c = 0; c <= 10; c++) begin
      reset = (c != 3);
      if (c == 0)      drive(1'b1, 3'b000, 1'b0);
      else if (c == 4) drive(1'b1, 3'b001, 1'b0);
      else             drive(1'b0, 3'b000, 1'b0);
      @(negedge clk);
      if (c == 3) begin
        m = {bus.cmd_ready, bus.start, bus.commit, bus.stall};
        total++;
        if (m !== 4'b0000) $display("FAIL reset_mid c3 obs=%b exp=0000", m);
        else passed++;
      end else begin
        e = ev(c == 0 || c == 4 || c == 10, c == 0 || c == 4,
               (c == 4) ? 3'b001 : 3'b000, 0, 0, c == 9,
               (c >= 1 && c <= 2) || (c >= 5 && c <= 9), 0);
        total++;
        if (obs !== e) $display("FAIL reset_mid c%0d obs=%b exp=%b", c, obs, e);
        else passed++;
      end
      next_cycle();
    end
    total++;
    if (commit_cnt - c0 !== 1) $display("FAIL reset_mid_commits got=%0d exp=1", commit_cnt - c0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    for (int c = 0; c <= 12; c++) begin
      if (c == 0)     drive(1'b1, 3'b001, 1'b0);
      else if (c <= 6) drive(1'b1, 3'b000, 1'b0);
      else            drive(1'b0, 3'b000, 1'b0);
      @(negedge clk);
      e = ev(c == 0 || c == 6 || c == 12, c == 0 || c == 6,
             (c == 0) ? 3'b001 : 3'b000, 0, 0, c == 5 || c == 11,
             (c >= 1 && c <= 5) || (c >= 7 && c <= 11), c >= 1 && c <= 5);
      total++;
      if (obs !== e) $display("FAIL back_to_back c%0d obs=%b exp=%b", c, obs, e);
      else passed++;
      next_cycle();
    end
  endtask

  initial begin
    drive(1'b0, 3'b000, 1'b0);
    reset = 1'b0;
    #1;
    test_reset();
    test_mult();
    test_divu_mflo();
    test_mt_and_idle_flush();
    test_flush_run();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
